// File: rtl/nested_int_ctrl_pkg.sv
// Shared defaults and helpers for the nested interrupt controller.
package nested_int_pkg;
    localparam int          DEF_NUM_IRQ    = 3;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_30AC;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_00C4;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] vec_of(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
        return base + id * stride;
    endfunction
endpackage

// File: rtl/nested_int_ctrl_prio_hi.sv
// Highest-set-bit finder: one-hot, binary index and valid flag.
module prio_hi #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_x,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = |i_x;
        // Ascending scan so the highest set bit is the last one written.
        for (int i = 0; i < N; i++) begin
            if (i_x[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/nested_int_ctrl.sv
// Nested interrupt controller: sync/capture, fixed-priority arbitration
// against the in-service level, and nesting bookkeeping until uret.
module nested_int_ctrl
    import nested_int_pkg::*;
#(
    parameter int          NUM_IRQ    = DEF_NUM_IRQ,
    parameter int          WIDTH      = 32,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    parameter int          MAX_NEST   = NUM_IRQ,
    parameter int          ID_W       = clog2_min1(NUM_IRQ),
    parameter int          DEPTH_W    = $clog2(MAX_NEST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] irq_level,
    input  logic               gie,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_IRQ-1:0] int_onehot,
    output logic [WIDTH-1:0]   int_vec,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [DEPTH_W-1:0] depth,
    output logic               eoi_err
);
    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_NEST);

    logic [NUM_IRQ-1:0] r_s1, r_s2, r_s3, r_pend, r_insvc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_eoi_err;

    logic [NUM_IRQ-1:0] w_cand, w_hp_oh, w_hs_oh, w_rise, w_clr, w_pend_nxt, w_insvc_nxt;
    logic [ID_W-1:0]    w_hp_idx, w_hs_idx;
    logic               w_hp_v, w_hs_v, w_req, w_ack, w_dec;

    assign w_cand = r_pend & irq_en & ~r_insvc;

    prio_hi #(.N(NUM_IRQ), .IDX_W(ID_W)) u_hp (
        .i_x(w_cand), .o_onehot(w_hp_oh), .o_idx(w_hp_idx), .o_valid(w_hp_v)
    );
    prio_hi #(.N(NUM_IRQ), .IDX_W(ID_W)) u_hs (
        .i_x(r_insvc), .o_onehot(w_hs_oh), .o_idx(w_hs_idx), .o_valid(w_hs_v)
    );

    assign w_req = gie & w_hp_v & (~w_hs_v | (w_hp_idx > w_hs_idx)) & (r_depth < MAX_D);
    assign w_ack = int_ack & w_req;
    assign w_dec = eoi & w_hs_v;

    // Edge mode: a new rising edge beats a same-cycle ack clear.
    assign w_rise      = r_s2 & ~r_s3;
    assign w_clr       = w_ack ? w_hp_oh : '0;
    assign w_pend_nxt  = (irq_level & r_s2) | (~irq_level & (w_rise | (r_pend & ~w_clr)));
    assign w_insvc_nxt = (r_insvc & ~(w_dec ? w_hs_oh : '0)) | (w_ack ? w_hp_oh : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pend    <= '0;
            r_insvc   <= '0;
            r_depth   <= '0;
            r_eoi_err <= 1'b0;
        end else begin
            r_s1    <= irq;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            if (w_ack && !w_dec)
                r_depth <= r_depth + 1'b1;
            else if (w_dec && !w_ack)
                r_depth <= r_depth - 1'b1;
            if (eoi && !w_hs_v)
                r_eoi_err <= 1'b1;
        end
    end

    assign int_req    = w_req;
    assign int_id     = w_req ? w_hp_idx : '0;
    assign int_onehot = w_req ? w_hp_oh : '0;
    assign int_vec    = w_req ? WIDTH'(vec_of(VEC_BASE, VEC_STRIDE, 32'(w_hp_idx))) : '0;
    assign pending    = r_pend;
    assign in_service = r_insvc;
    assign depth      = r_depth;
    assign eoi_err    = r_eoi_err;
endmodule

// File: tb/tb_nested_int_ctrl.sv
// Directed bench for nested_int_ctrl; a second instance with MAX_NEST=1
// shares the stimulus to exercise the nesting-depth limit.
module tb_nested_int_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] irq, irq_en, irq_level;
    logic       gie, int_ack, eoi;

    logic        int_req, eoi_err, req1, eoi_err1;
    logic [1:0]  int_id, id1, depth;
    logic [0:0]  depth1;
    logic [2:0]  int_onehot, pending, in_service, oh1, pend1, isv1;
    logic [31:0] int_vec, vec1;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    nested_int_ctrl dut (
        .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .irq_level(irq_level),
        .gie(gie), .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id),
        .int_onehot(int_onehot), .int_vec(int_vec), .pending(pending),
        .in_service(in_service), .depth(depth), .eoi_err(eoi_err)
    );

    nested_int_ctrl #(.MAX_NEST(1)) dut1 (
        .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .irq_level(irq_level),
        .gie(gie), .int_ack(int_ack), .eoi(eoi), .int_req(req1), .int_id(id1),
        .int_onehot(oh1), .int_vec(vec1), .pending(pend1),
        .in_service(isv1), .depth(depth1), .eoi_err(eoi_err1)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise irq bit for two cycles then wait until it reaches pending.
    task automatic pulse_irq(input int ch);
        irq[ch] = 1'b1;
        tick(2);
        irq[ch] = 1'b0;
        tick(1);
    endtask

    task automatic do_ack();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq = '0; irq_en = 3'b111; irq_level = '0;
        gie = 1'b1; int_ack = 1'b0; eoi = 1'b0;
        tick(2);
        rst = 1'b0;
        tick();
        chk_cnt++;
        if ({int_req, int_id, int_onehot, int_vec, pending, in_service, depth, eoi_err} !== '0)
            $display("FAIL reset_state got req=%b id=%0d oh=%b vec=%h pend=%b isv=%b d=%0d err=%b",
                     int_req, int_id, int_onehot, int_vec, pending, in_service, depth, eoi_err);
        else pass_cnt++;
    endtask

    task automatic test_single_edge();
        irq[0] = 1'b1;
        tick(2);
        irq[0] = 1'b0;
        chk_cnt++;
        if (int_req !== 1'b0) $display("FAIL edge_latency_early got %b exp 0", int_req);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({int_req, int_id, int_onehot, int_vec} !== {1'b1, 2'd0, 3'b001, 32'h30AC})
            $display("FAIL edge_req got req=%b id=%0d oh=%b vec=%h exp 1/0/001/30ac",
                     int_req, int_id, int_onehot, int_vec);
        else pass_cnt++;
        do_ack();
        chk_cnt++;
        if ({pending, in_service, depth} !== {3'b000, 3'b001, 2'd1})
            $display("FAIL edge_ack got pend=%b isv=%b d=%0d exp 000/001/1", pending, in_service, depth);
        else pass_cnt++;
    endtask

    task automatic test_nesting();
        pulse_irq(2);
        chk_cnt++;
        if ({int_req, int_id, int_vec} !== {1'b1, 2'd2, 32'h3234})
            $display("FAIL nest_req got req=%b id=%0d vec=%h exp 1/2/3234", int_req, int_id, int_vec);
        else pass_cnt++;
        chk_cnt++;
        if ({req1, isv1} !== {1'b0, 3'b001})
            $display("FAIL max_nest1_block got req=%b isv=%b exp 0/001", req1, isv1);
        else pass_cnt++;
        do_ack();
        chk_cnt++;
        if ({in_service, depth, int_req} !== {3'b101, 2'd2, 1'b0})
            $display("FAIL nest_ack got isv=%b d=%0d req=%b exp 101/2/0", in_service, depth, int_req);
        else pass_cnt++;
        do_eoi();
        chk_cnt++;
        if ({in_service, depth} !== {3'b001, 2'd1})
            $display("FAIL nest_eoi got isv=%b d=%0d exp 001/1", in_service, depth);
        else pass_cnt++;
    endtask

    task automatic test_no_preempt();
        pulse_irq(2);
        do_ack();
        pulse_irq(1);
        chk_cnt++;
        if ({int_req, pending, in_service} !== {1'b0, 3'b010, 3'b101})
            $display("FAIL no_preempt got req=%b pend=%b isv=%b exp 0/010/101", int_req, pending, in_service);
        else pass_cnt++;
        do_eoi();
        chk_cnt++;
        if ({int_req, int_id, int_onehot, int_vec} !== {1'b1, 2'd1, 3'b010, 32'h3170})
            $display("FAIL after_eoi_req got req=%b id=%0d oh=%b vec=%h exp 1/1/010/3170",
                     int_req, int_id, int_onehot, int_vec);
        else pass_cnt++;
        gie = 1'b0;
        #1;
        chk_cnt++;
        if ({int_req, int_vec} !== {1'b0, 32'h0})
            $display("FAIL gie_gate got req=%b vec=%h exp 0/0", int_req, int_vec);
        else pass_cnt++;
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        chk_cnt++;
        if ({in_service, depth, pending} !== {3'b001, 2'd1, 3'b010})
            $display("FAIL ack_ignored got isv=%b d=%0d pend=%b exp 001/1/010", in_service, depth, pending);
        else pass_cnt++;
        gie = 1'b1;
        do_ack();
        do_eoi();
        do_eoi();
        chk_cnt++;
        if ({in_service, depth, pending} !== {3'b000, 2'd0, 3'b000})
            $display("FAIL unwind got isv=%b d=%0d pend=%b exp 000/0/000", in_service, depth, pending);
        else pass_cnt++;
    endtask

    task automatic test_level();
        irq_level[1] = 1'b1;
        irq[1] = 1'b1;
        tick(3);
        do_ack();
        chk_cnt++;
        if ({pending[1], int_req, in_service} !== {1'b1, 1'b0, 3'b010})
            $display("FAIL level_ack got pend1=%b req=%b isv=%b exp 1/0/010", pending[1], int_req, in_service);
        else pass_cnt++;
        do_eoi();
        chk_cnt++;
        if ({int_req, int_id} !== {1'b1, 2'd1})
            $display("FAIL level_rearm got req=%b id=%0d exp 1/1", int_req, int_id);
        else pass_cnt++;
        irq[1] = 1'b0;
        tick(2);
        chk_cnt++;
        if (pending[1] !== 1'b1) $display("FAIL level_drop_early got %b exp 1", pending[1]);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({pending[1], int_req} !== {1'b0, 1'b0})
            $display("FAIL level_drop got pend1=%b req=%b exp 0/0", pending[1], int_req);
        else pass_cnt++;
        irq_level[1] = 1'b0;
    endtask

    task automatic test_eoi_err();
        chk_cnt++;
        if (eoi_err !== 1'b0) $display("FAIL eoi_err_pre got %b exp 0", eoi_err);
        else pass_cnt++;
        do_eoi();
        tick();
        chk_cnt++;
        if ({eoi_err, depth, in_service} !== {1'b1, 2'd0, 3'b000})
            $display("FAIL eoi_err got err=%b d=%0d isv=%b exp 1/0/000", eoi_err, depth, in_service);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        pulse_irq(0);
        do_ack();
        pulse_irq(2);
        int_ack = 1'b1; eoi = 1'b1;
        tick();
        int_ack = 1'b0; eoi = 1'b0;
        chk_cnt++;
        if ({in_service, depth} !== {3'b100, 2'd1})
            $display("FAIL ack_eoi_same got isv=%b d=%0d exp 100/1", in_service, depth);
        else pass_cnt++;
        do_eoi();
    endtask

    task automatic test_reset_mid_nest();
        pulse_irq(0);
        do_ack();
        pulse_irq(2);
        do_ack();
        pulse_irq(1);
        chk_cnt++;
        if ({in_service, pending, depth} !== {3'b101, 3'b010, 2'd2})
            $display("FAIL mid_nest_setup got isv=%b pend=%b d=%0d exp 101/010/2", in_service, pending, depth);
        else pass_cnt++;
        rst = 1'b1;
        #2;
        chk_cnt++;
        if ({int_req, int_id, int_onehot, int_vec, pending, in_service, depth, eoi_err} !== '0)
            $display("FAIL async_reset got req=%b pend=%b isv=%b d=%0d err=%b exp all 0",
                     int_req, pending, in_service, depth, eoi_err);
        else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_nesting();
        test_no_preempt();
        test_level();
        test_eoi_err();
        test_back_to_back();
        test_reset_mid_nest();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
